// File: rtl/fx_pkg.sv
// Shared types and constants for the FX chain blocks: stereo sample type,
// Q1.15 gain constants and the divider state encoding.
package fx_pkg;

   localparam int FX_DATA_W = 16;

   typedef logic [1:0][FX_DATA_W-1:0] stereo_t;

   localparam logic [15:0] GAIN_UNITY = 16'h8000;
   localparam int          GAIN_FRAC  = 15;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DONE
   } div_state_e;

endpackage

// File: rtl/fx_comp_div.sv
// 16-bit unsigned restoring divider, one quotient bit per cycle, start/busy/done
// handshake. The caller guarantees dividend[31:16] < divisor so the quotient fits 16 bits.
module fx_comp_div
   import fx_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [31:0] dividend_i,
   input  logic [15:0] divisor_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] quot_o
);

   div_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] rem_q, rem_d;
   logic [15:0] quot_q, quot_d;
   logic [15:0] dvsr_q, dvsr_d;
   logic [16:0] trial;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      dvsr_d  = dvsr_q;
      busy_o  = 1'b1;
      done_o  = 1'b0;
      // quotient register doubles as the dividend shift register
      trial   = {rem_q, quot_q[15]};
      unique case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               state_d = DIV;
               cnt_d   = '0;
               rem_d   = dividend_i[31:16];
               quot_d  = dividend_i[15:0];
               dvsr_d  = divisor_i;
            end
         end
         DIV: begin
            if (trial >= {1'b0, dvsr_q}) begin
               rem_d  = 16'(trial - {1'b0, dvsr_q});
               quot_d = {quot_q[14:0], 1'b1};
            end else begin
               rem_d  = trial[15:0];
               quot_d = {quot_q[14:0], 1'b0};
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign quot_o = quot_q;

endmodule

// File: rtl/fx_compressor.sv
// Stereo feed-forward compressor: peak detect, attack/release envelope, 2^RATIO_SH:1 gain
// via sequential divider, 2-cycle scaling pipeline. FX_COMP_GR_METER_EN adds gr_gain/clip.
module fx_compressor
   import fx_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int PARAM_W  = 7,
   parameter int RATIO_SH = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [1:0][DATA_W-1:0] audio_in,
   input  logic [PARAM_W-1:0]     threshold,
   input  logic [PARAM_W-1:0]     attack,
   input  logic [PARAM_W-1:0]     release_i,
   output logic                   out_valid,
   output logic [1:0][DATA_W-1:0] audio_out
`ifdef FX_COMP_GR_METER_EN
   ,
   output logic [15:0]            gr_gain,
   output logic [0:0]             clip
`endif
);

   localparam int LVL_W  = DATA_W - 1;
   localparam int THR_SH = DATA_W - 1 - PARAM_W;
   localparam int PROD_W = DATA_W + 17;
   localparam logic signed [PROD_W-1:0] S_MAX = PROD_W'(2**(DATA_W-1) - 1);
   localparam logic signed [PROD_W-1:0] S_MIN = PROD_W'(-(2**(DATA_W-1)));

   function automatic logic [LVL_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
      logic [DATA_W-1:0] m;
      m = x[DATA_W-1] ? -x : x;
      return m[DATA_W-1] ? '1 : m[LVL_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] sat_out(input logic signed [PROD_W-1:0] p);
      logic signed [PROD_W-1:0] s;
      s = p >>> GAIN_FRAC;
      if (s > S_MAX)      return S_MAX[DATA_W-1:0];
      else if (s < S_MIN) return S_MIN[DATA_W-1:0];
      else                return s[DATA_W-1:0];
   endfunction

   logic [LVL_W-1:0]          env_q, env_d;
   logic [LVL_W-1:0]          lvl_l, lvl_r, lvl, up_step, dn_step;
   logic [LVL_W-1:0]          thr, target;
   logic [3:0]                atk_sh, rel_sh;
   logic                      upd_q, pend_q, pend_d;
   logic                      launch, need_div;
   logic [15:0]               gain_q, gain_d, quot;
   logic                      div_busy, div_done;
   logic [31:0]               dividend;
   logic signed [PROD_W-1:0]  prod_p1 [2];
   logic                      vld_p1, vld_p2;
   logic [1:0][DATA_W-1:0]    aout_p2;
   logic                      unused_ctl;

   assign unused_ctl = ^{attack[PARAM_W-5:0], release_i[PARAM_W-5:0]};

   always_comb begin
      lvl_l   = abs_sat(audio_in[0]);
      lvl_r   = abs_sat(audio_in[1]);
      lvl     = (lvl_l > lvl_r) ? lvl_l : lvl_r;
      atk_sh  = attack[PARAM_W-1 -: 4];
      rel_sh  = release_i[PARAM_W-1 -: 4];
      up_step = (lvl - env_q) >> atk_sh;
      dn_step = (env_q - lvl) >> rel_sh;
      // release always makes progress so the envelope cannot stall above the level
      if (dn_step == '0) dn_step = LVL_W'(1);
      env_d = env_q;
      if (in_valid) begin
         if (lvl > env_q)      env_d = env_q + up_step;
         else if (lvl < env_q) env_d = env_q - dn_step;
      end
   end

   always_comb begin
      thr      = LVL_W'(threshold) << THR_SH;
      need_div = (env_q > thr);
      target   = thr + ((env_q - thr) >> RATIO_SH);
      dividend = 32'(target) << GAIN_FRAC;
      launch   = (upd_q | pend_q) & ~div_busy;
      pend_d   = pend_q;
      if (launch)     pend_d = 1'b0;
      else if (upd_q) pend_d = 1'b1;
      gain_d = gain_q;
      if (launch && !need_div) gain_d = GAIN_UNITY;
      else if (div_done)       gain_d = (quot > GAIN_UNITY) ? GAIN_UNITY : quot;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         env_q  <= '0;
         upd_q  <= 1'b0;
         pend_q <= 1'b0;
         gain_q <= GAIN_UNITY;
      end else begin
         env_q  <= env_d;
         upd_q  <= in_valid;
         pend_q <= pend_d;
         gain_q <= gain_d;
      end
   end

   fx_comp_div u_div (
      .clk        (clk),
      .reset      (reset),
      .start_i    (launch & need_div),
      .dividend_i (dividend),
      .divisor_i  (16'(env_q)),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quot_o     (quot)
   );

   // stage 1: capture both channels against one gain value
   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         for (int c = 0; c < 2; c++) begin
            prod_p1[c] <= PROD_W'($signed(audio_in[c])) * PROD_W'($signed({1'b0, gain_q}));
         end
      end
   end

   // stage 2: requantise to DATA_W with saturation
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p2  <= 1'b0;
         aout_p2 <= '0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            for (int c = 0; c < 2; c++) begin
               aout_p2[c] <= sat_out(prod_p1[c]);
            end
         end
      end
   end

   assign out_valid = vld_p2;
   assign audio_out = aout_p2;

`ifdef FX_COMP_GR_METER_EN
   function automatic logic sat_hit(input logic signed [PROD_W-1:0] p);
      logic signed [PROD_W-1:0] s;
      s = p >>> GAIN_FRAC;
      return (s > S_MAX) || (s < S_MIN);
   endfunction

   logic clip_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         clip_q <= 1'b0;
      end else if (vld_p1 && (sat_hit(prod_p1[0]) || sat_hit(prod_p1[1]))) begin
         clip_q <= 1'b1;
      end
   end

   assign gr_gain = gain_q;
   assign clip    = clip_q;
`else
   // meter outputs and sticky clip flag are not built
`endif

endmodule
